// File: rtl/spec_issue_scoreboard_pkg.sv
// Shared types and helpers for the speculative-issue scoreboard.
// The state encoding and field extraction are common to the top level and to the bench.
package spec_issue_scoreboard_pkg;

  typedef enum logic {
    ST_OPEN  = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_t;

  localparam int DEF_UCODE_W  = 32;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_REG_W    = 8;
  localparam int DEF_DST_LSB  = 0;
  localparam int DEF_SRCB_LSB = 8;
  localparam int DEF_SRCA_LSB = 16;
  localparam int DEF_EXCL_LSB = 5;
  localparam int DEF_EXCL_MSB = 11;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_CNT_W    = 16;

  // Wide carrier so one helper serves every word width; callers truncate to the field width.
  localparam int MAX_W = 128;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic wide_t field_at(input wide_t word, input int lsb);
    return word >> lsb;
  endfunction

  function automatic wide_t excl_field(input wide_t ucode, input int lsb, input int msb);
    wide_t mask;
    mask = (wide_t'(1) << (msb - lsb + 1)) - wide_t'(1);
    return (ucode >> lsb) & mask;
  endfunction

endpackage

// File: rtl/spec_issue_scoreboard_if.sv
// Handshake bundle between the micro-code sequencer side and the scoreboard.
interface spec_issue_scoreboard_if #(
  parameter int UCODE_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
);
  logic                     norm_valid;
  logic                     norm_ready;
  logic [UCODE_W-1:0]       norm_ucode;
  logic [INSTR_W-1:0]       norm_instr;
  logic                     retire;
  logic                     flush;
  logic                     spec_valid;
  logic [UCODE_W-1:0]       spec_ucode;
  logic [INSTR_W-1:0]       spec_instr;
  logic                     spec_accept;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     spec_blocked;
  logic [CNT_W-1:0]         issued_cnt;
  logic [CNT_W-1:0]         reject_cnt;

  modport master (
    output norm_valid, norm_ucode, norm_instr, retire, flush,
           spec_valid, spec_ucode, spec_instr,
    input  norm_ready, spec_accept, occupancy, spec_blocked, issued_cnt, reject_cnt
  );

  modport slave (
    input  norm_valid, norm_ucode, norm_instr, retire, flush,
           spec_valid, spec_ucode, spec_instr,
    output norm_ready, spec_accept, occupancy, spec_blocked, issued_cnt, reject_cnt
  );
endinterface

// File: rtl/spec_issue_scoreboard_conflict_cmp.sv
// Single-candidate conflict test: shared resource bit, or candidate destination
// feeding either speculative source (register 0 optionally exempt).
module spec_conflict_cmp #(
  parameter int UCODE_W   = 32,
  parameter int REG_W     = 8,
  parameter bit REG0_FREE = 1'b1
) (
  input  logic               cand_valid,
  input  logic [UCODE_W-1:0] cand_ucode,
  input  logic [REG_W-1:0]   cand_dest,
  input  logic [UCODE_W-1:0] spec_ucode,
  input  logic [REG_W-1:0]   src_a,
  input  logic [REG_W-1:0]   src_b,
  output logic               conflict
);
  logic dest_live;
  logic dest_hit;
  logic res_hit;

  always_comb begin
    dest_live = !REG0_FREE || (cand_dest != '0);
    dest_hit  = dest_live && ((cand_dest == src_a) || (cand_dest == src_b));
    res_hit   = |(cand_ucode & spec_ucode);
    conflict  = cand_valid && (res_hit || dest_hit);
  end
endmodule

// File: rtl/spec_issue_scoreboard.sv
// In-flight window of normal micro-ops plus the same-cycle verdict on whether a
// speculative micro-op may issue alongside them.
module spec_issue_scoreboard
  import spec_issue_scoreboard_pkg::*;
#(
  parameter int UCODE_W   = DEF_UCODE_W,
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int REG_W     = DEF_REG_W,
  parameter int DST_LSB   = DEF_DST_LSB,
  parameter int SRCB_LSB  = DEF_SRCB_LSB,
  parameter int SRCA_LSB  = DEF_SRCA_LSB,
  parameter int EXCL_LSB  = DEF_EXCL_LSB,
  parameter int EXCL_MSB  = DEF_EXCL_MSB,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit REG0_FREE = 1'b1
) (
  input logic clk,
  input logic rst,
  spec_issue_scoreboard_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  sb_state_t          state, state_next;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, off;
  logic [OCC_W-1:0]   occ, occ_next;
  logic [CNT_W-1:0]   issued, reject;
  logic [UCODE_W-1:0] win_ucode [DEPTH];
  logic [REG_W-1:0]   win_dest  [DEPTH];
  logic [DEPTH-1:0]   ent_vld;
  logic [UCODE_W-1:0] cand_ucode [DEPTH+1];
  logic [REG_W-1:0]   cand_dest  [DEPTH+1];
  logic [DEPTH:0]     cand_vld, hit;
  logic [REG_W-1:0]   norm_dest, spec_src_a, spec_src_b;
  logic               push, pop, push_excl, spec_excl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign norm_dest  = REG_W'(field_at(wide_t'(bus.norm_instr), DST_LSB));
  assign spec_src_a = REG_W'(field_at(wide_t'(bus.spec_instr), SRCA_LSB));
  assign spec_src_b = REG_W'(field_at(wide_t'(bus.spec_instr), SRCB_LSB));
  assign spec_excl  = excl_field(wide_t'(bus.spec_ucode), EXCL_LSB, EXCL_MSB) != '0;

  assign bus.norm_ready = rst || (occ < OCC_W'(DEPTH)) || bus.retire;
  assign push      = bus.norm_valid && bus.norm_ready;
  assign pop       = bus.retire && (occ != '0);
  assign push_excl = push && (excl_field(wide_t'(bus.norm_ucode), EXCL_LSB, EXCL_MSB) != '0);

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    off     = '0;
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rd_ptr;
      ent_vld[i] = {1'b0, off} < occ;
      cand_ucode[i] = win_ucode[i];
      cand_dest[i]  = win_dest[i];
    end
    cand_ucode[DEPTH] = bus.norm_ucode;
    cand_dest[DEPTH]  = norm_dest;
  end

  assign cand_vld = {push, ent_vld};

  for (genvar g = 0; g <= DEPTH; g++) begin : g_cmp
    spec_conflict_cmp #(
      .UCODE_W  (UCODE_W),
      .REG_W    (REG_W),
      .REG0_FREE(REG0_FREE)
    ) u_cmp (
      .cand_valid(cand_vld[g]),
      .cand_ucode(cand_ucode[g]),
      .cand_dest (cand_dest[g]),
      .spec_ucode(bus.spec_ucode),
      .src_a     (spec_src_a),
      .src_b     (spec_src_b),
      .conflict  (hit[g])
    );
  end

  assign bus.spec_accept  = !((|hit) || spec_excl || push_excl || (state == ST_DRAIN) ||
                              bus.flush || rst);
  assign bus.occupancy    = occ;
  assign bus.spec_blocked = (state == ST_DRAIN);
  assign bus.issued_cnt   = issued;
  assign bus.reject_cnt   = reject;

  always_comb begin
    occ_next = bus.flush ? '0 : occ + OCC_W'(push) - OCC_W'(pop);
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = ST_OPEN;
    end else begin
      case (state)
        ST_OPEN:  if (push_excl) state_next = ST_DRAIN;
        ST_DRAIN: if (occ_next == '0 && !push_excl) state_next = ST_OPEN;
        default:  state_next = ST_OPEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_OPEN;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      issued <= '0;
      reject <= '0;
    end else begin
      occ <= occ_next;
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (bus.spec_valid) begin
        if (bus.spec_accept) issued <= sat_inc(issued);
        else                 reject <= sat_inc(reject);
      end
    end
  end

  // Payload storage carries no reset; liveness comes from the pointers.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      win_ucode[wr_ptr] <= bus.norm_ucode;
      win_dest[wr_ptr]  <= norm_dest;
    end
  end
endmodule

// File: tb/tb_spec_issue_scoreboard.sv
// Directed bench for spec_issue_scoreboard: default build, REG0_FREE=0 build and CNT_W=2 build.
module tb_spec_issue_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  spec_issue_scoreboard_if                bus    ();
  spec_issue_scoreboard_if                bus_r0 ();
  spec_issue_scoreboard_if #(.CNT_W(2))   bus_c2 ();

  spec_issue_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));
  spec_issue_scoreboard #(.REG0_FREE(1'b0)) dut_r0 (.clk(clk), .rst(rst), .bus(bus_r0));
  spec_issue_scoreboard #(.CNT_W(2)) dut_c2 (.clk(clk), .rst(rst), .bus(bus_c2));

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    return {8'h00, a, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic idle_all();
    bus.norm_valid = 0; bus.norm_ucode = 0; bus.norm_instr = 0; bus.retire = 0; bus.flush = 0;
    bus.spec_valid = 0; bus.spec_ucode = 0; bus.spec_instr = 0;
    bus_r0.norm_valid = 0; bus_r0.norm_ucode = 0; bus_r0.norm_instr = 0; bus_r0.retire = 0;
    bus_r0.flush = 0; bus_r0.spec_valid = 0; bus_r0.spec_ucode = 0; bus_r0.spec_instr = 0;
    bus_c2.norm_valid = 0; bus_c2.norm_ucode = 0; bus_c2.norm_instr = 0; bus_c2.retire = 0;
    bus_c2.flush = 0; bus_c2.spec_valid = 0; bus_c2.spec_ucode = 0; bus_c2.spec_instr = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1;
    tick(); tick(); mid();
    n_chk++; if (bus.norm_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", bus.norm_ready); end
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL rst_accept: got %0b want 0", bus.spec_accept); end
    rst = 0;
    tick();
    n_chk++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", bus.occupancy); end
    n_chk++; if (bus.spec_blocked !== 1'b0) begin n_fail++; $display("FAIL rst_blocked: got %0b want 0", bus.spec_blocked); end
    n_chk++; if (bus.issued_cnt !== 16'd0 || bus.reject_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", bus.issued_cnt, bus.reject_cnt); end
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL empty_accept: got %0b want 1", bus.spec_accept); end
  endtask

  task automatic test_dependency();
    bus.norm_valid = 1; bus.norm_ucode = 32'h1; bus.norm_instr = mk(8'h00, 8'h00, 8'h05);
    tick();
    bus.norm_valid = 0;
    n_chk++; if (bus.occupancy !== 3'd1) begin n_fail++; $display("FAIL dep_occ: got %0d want 1", bus.occupancy); end
    bus.spec_valid = 1; bus.spec_ucode = 32'h2; bus.spec_instr = mk(8'h05, 8'h00, 8'h00);
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL dep_srca: got %0b want 0", bus.spec_accept); end
    tick();
    bus.spec_valid = 0;
    n_chk++; if (bus.reject_cnt !== 16'd1 || bus.issued_cnt !== 16'd0) begin n_fail++;
      $display("FAIL dep_rej_cnt: got iss=%0d rej=%0d want 0/1", bus.issued_cnt, bus.reject_cnt); end
    bus.retire = 1;
    tick();
    bus.retire = 0;
    bus.spec_valid = 1;
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL dep_after_retire: got %0b want 1", bus.spec_accept); end
    tick();
    bus.spec_valid = 0;
    n_chk++; if (bus.issued_cnt !== 16'd1 || bus.reject_cnt !== 16'd1) begin n_fail++;
      $display("FAIL dep_iss_cnt: got iss=%0d rej=%0d want 1/1", bus.issued_cnt, bus.reject_cnt); end
    bus.norm_valid = 1; bus.norm_ucode = 32'h1; bus.norm_instr = mk(8'h00, 8'h00, 8'h06);
    tick();
    bus.norm_valid = 0;
    bus.spec_instr = mk(8'h00, 8'h06, 8'h00);
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL dep_srcb: got %0b want 0", bus.spec_accept); end
    bus.retire = 1;
    tick();
    bus.retire = 0;
  endtask

  task automatic test_full_window();
    logic [31:0] uc [4];
    uc[0] = 32'h1; uc[1] = 32'h2; uc[2] = 32'h4; uc[3] = 32'h10;
    bus.spec_ucode = 32'h1; bus.spec_instr = mk(8'h20, 8'h21, 8'h00);
    bus.norm_valid = 1; bus.norm_ucode = uc[0]; bus.norm_instr = mk(8'h00, 8'h00, 8'h11);
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL push_candidate: got %0b want 0", bus.spec_accept); end
    tick();
    for (int i = 1; i < 4; i++) begin
      bus.norm_ucode = uc[i]; bus.norm_instr = mk(8'h00, 8'h00, 8'(8'h11 + i));
      tick();
    end
    bus.norm_valid = 0;
    n_chk++; if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d want 4", bus.occupancy); end
    bus.spec_ucode = 32'h10;
    mid();
    n_chk++; if (bus.norm_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", bus.norm_ready); end
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL full_entry3: got %0b want 0", bus.spec_accept); end
    bus.spec_ucode = 32'h8;
    #1;
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL full_disjoint: got %0b want 1", bus.spec_accept); end
    tick();
    bus.norm_valid = 1; bus.norm_ucode = 32'h1000; bus.norm_instr = mk(8'h00, 8'h00, 8'h15);
    bus.retire = 1;
    mid();
    n_chk++; if (bus.norm_ready !== 1'b1) begin n_fail++; $display("FAIL full_push_pop_ready: got %0b want 1", bus.norm_ready); end
    tick();
    bus.norm_valid = 0; bus.retire = 0;
    n_chk++; if (bus.occupancy !== 3'd4) begin n_fail++; $display("FAIL full_push_pop_occ: got %0d want 4", bus.occupancy); end
    bus.spec_ucode = 32'h1;
    #1;
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL retired_gone: got %0b want 1", bus.spec_accept); end
    bus.spec_ucode = 32'h1000;
    #1;
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL new_present: got %0b want 0", bus.spec_accept); end
    bus.retire = 1;
    repeat (5) tick();
    bus.retire = 0;
    n_chk++; if (bus.occupancy !== 3'd0) begin n_fail++; $display("FAIL drain_occ: got %0d want 0", bus.occupancy); end
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL drain_accept: got %0b want 1", bus.spec_accept); end
    bus.spec_ucode = 32'h0;
  endtask

  task automatic test_exclusive();
    bus.spec_ucode = 32'h4000; bus.spec_instr = mk(8'h40, 8'h41, 8'h00);
    bus.norm_valid = 1; bus.norm_ucode = 32'h80; bus.norm_instr = mk(8'h00, 8'h00, 8'h30);
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL excl_push_accept: got %0b want 0", bus.spec_accept); end
    tick();
    bus.norm_ucode = 32'h2; bus.norm_instr = mk(8'h00, 8'h00, 8'h31);
    tick();
    bus.norm_valid = 0;
    n_chk++; if (bus.spec_blocked !== 1'b1 || bus.occupancy !== 3'd2) begin n_fail++;
      $display("FAIL excl_drain: got blocked=%0b occ=%0d want 1/2", bus.spec_blocked, bus.occupancy); end
    bus.spec_valid = 1;
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL excl_drain_accept: got %0b want 0", bus.spec_accept); end
    tick();
    bus.spec_valid = 0;
    n_chk++; if (bus.reject_cnt !== 16'd2) begin n_fail++; $display("FAIL excl_rej_cnt: got %0d want 2", bus.reject_cnt); end
    bus.retire = 1;
    tick();
    n_chk++; if (bus.spec_blocked !== 1'b1 || bus.occupancy !== 3'd1) begin n_fail++;
      $display("FAIL excl_hold: got blocked=%0b occ=%0d want 1/1", bus.spec_blocked, bus.occupancy); end
    tick();
    bus.retire = 0;
    n_chk++; if (bus.spec_blocked !== 1'b0 || bus.occupancy !== 3'd0) begin n_fail++;
      $display("FAIL excl_release: got blocked=%0b occ=%0d want 0/0", bus.spec_blocked, bus.occupancy); end
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL excl_reopen_accept: got %0b want 1", bus.spec_accept); end
  endtask

  task automatic test_reg0();
    bus.norm_valid = 1; bus.norm_ucode = 32'h1; bus.norm_instr = 32'h0;
    bus_r0.norm_valid = 1; bus_r0.norm_ucode = 32'h1; bus_r0.norm_instr = 32'h0;
    tick();
    bus.norm_valid = 0; bus_r0.norm_valid = 0;
    bus.spec_ucode = 32'h2; bus.spec_instr = 32'h0;
    bus_r0.spec_ucode = 32'h2; bus_r0.spec_instr = 32'h0;
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL reg0_free: got %0b want 1", bus.spec_accept); end
    n_chk++; if (bus_r0.spec_accept !== 1'b0) begin n_fail++; $display("FAIL reg0_dep: got %0b want 0", bus_r0.spec_accept); end
    bus.retire = 1; bus_r0.retire = 1;
    tick();
    bus.retire = 0; bus_r0.retire = 0;
  endtask

  task automatic test_flush();
    logic [31:0] uc [3];
    uc[0] = 32'h80; uc[1] = 32'h2; uc[2] = 32'h4;
    bus.norm_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.norm_ucode = uc[i]; bus.norm_instr = mk(8'h00, 8'h00, 8'(8'h50 + i));
      tick();
    end
    n_chk++; if (bus.occupancy !== 3'd3 || bus.spec_blocked !== 1'b1) begin n_fail++;
      $display("FAIL flush_setup: got occ=%0d blocked=%0b want 3/1", bus.occupancy, bus.spec_blocked); end
    bus.flush = 1; bus.norm_ucode = 32'h88; bus.norm_instr = mk(8'h00, 8'h00, 8'h53);
    bus.spec_ucode = 32'h4000; bus.spec_instr = mk(8'h60, 8'h61, 8'h00);
    mid();
    n_chk++; if (bus.norm_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", bus.norm_ready); end
    n_chk++; if (bus.spec_accept !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %0b want 0", bus.spec_accept); end
    tick();
    bus.flush = 0; bus.norm_valid = 0;
    n_chk++; if (bus.occupancy !== 3'd0 || bus.spec_blocked !== 1'b0) begin n_fail++;
      $display("FAIL flush_result: got occ=%0d blocked=%0b want 0/0", bus.occupancy, bus.spec_blocked); end
    bus.spec_ucode = 32'h8; bus.spec_instr = mk(8'h53, 8'h50, 8'h00);
    mid();
    n_chk++; if (bus.spec_accept !== 1'b1) begin n_fail++; $display("FAIL flush_push_gone: got %0b want 1", bus.spec_accept); end
    bus.norm_valid = 1; bus.norm_ucode = 32'h1; bus.norm_instr = mk(8'h00, 8'h00, 8'h54);
    tick();
    bus.norm_valid = 0; bus.spec_ucode = 32'h1;
    mid();
    n_chk++; if (bus.spec_accept !== 1'b0 || bus.occupancy !== 3'd1) begin n_fail++;
      $display("FAIL flush_reuse: got accept=%0b occ=%0d want 0/1", bus.spec_accept, bus.occupancy); end
    bus.retire = 1;
    tick();
    bus.retire = 0; bus.spec_ucode = 32'h0;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    bus_c2.norm_valid = 1; bus_c2.norm_ucode = 32'h1; bus_c2.norm_instr = mk(8'h00, 8'h00, 8'h71);
    tick();
    bus_c2.norm_ucode = 32'h2; bus_c2.norm_instr = mk(8'h00, 8'h00, 8'h72);
    tick();
    bus_c2.norm_valid = 0;
    bus_c2.spec_valid = 1; bus_c2.spec_ucode = 32'h20; bus_c2.spec_instr = mk(8'h40, 8'h41, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k < 3) ? 2'(k) : 2'd3;
      n_chk++; if (bus_c2.reject_cnt !== want) begin n_fail++;
        $display("FAIL sat_reject_%0d: got %0d want %0d", k, bus_c2.reject_cnt, want); end
    end
    bus_c2.spec_ucode = 32'h4000;
    tick();
    n_chk++; if (bus_c2.issued_cnt !== 2'd1 || bus_c2.reject_cnt !== 2'd3) begin n_fail++;
      $display("FAIL sat_issue: got iss=%0d rej=%0d want 1/3", bus_c2.issued_cnt, bus_c2.reject_cnt); end
    rst = 1;
    mid();
    n_chk++; if (bus_c2.spec_accept !== 1'b0) begin n_fail++; $display("FAIL midrst_accept: got %0b want 0", bus_c2.spec_accept); end
    tick();
    rst = 0; bus_c2.spec_valid = 0;
    n_chk++; if (bus_c2.issued_cnt !== 2'd0 || bus_c2.reject_cnt !== 2'd0 || bus_c2.occupancy !== 3'd0) begin n_fail++;
      $display("FAIL midrst_state: got iss=%0d rej=%0d occ=%0d want 0/0/0",
               bus_c2.issued_cnt, bus_c2.reject_cnt, bus_c2.occupancy); end
    n_chk++; if (bus.issued_cnt !== 16'd0 || bus.reject_cnt !== 16'd0) begin n_fail++;
      $display("FAIL midrst_main: got iss=%0d rej=%0d want 0/0", bus.issued_cnt, bus.reject_cnt); end
  endtask

  initial begin
    test_reset();
    test_dependency();
    test_full_window();
    test_exclusive();
    test_reg0();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule
